instruction_fetch: RTL and testbench

Fetch stage of the CPU core: owns the program counter, drives the address into the combinational program memory, and captures the returned 16-bit instruction into an instruction register. Instructions are presented to decode with a valid/ready handshake. Decode/execute can redirect the PC for taken branches and jumps, and the block flushes the in-flight instruction when that happens. The block sits between program memory (upstream) and decode (downstream).

---
 rtl/instruction_fetch.sv | 98 +++++++++
 tb/tb_instruction_fetch.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage of the CPU core.
// Owns the program counter and drives it into the combinational program memory.
// Captures each returned word into an instruction register, which decode consumes
// over a valid/ready handshake. A taken branch or jump redirects the PC and
// flushes the in-flight instruction, so a redirect costs one bubble.
module instruction_fetch #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  output logic [ADDR_WIDTH-1:0] pm_addr,
  input  logic [15:0]           pm_data,
  output logic [15:0]           instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic [15:0]           fetch_count
);

  localparam logic [ADDR_WIDTH-1:0] PC_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PC_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [15:0]           NOP     = 16'hFFFF;
  localparam logic [15:0]           CNT_MAX = 16'hFFFF;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]           ir_q, ir_d;
  logic [ADDR_WIDTH-1:0] ir_pc_q, ir_pc_d;
  logic                  ir_valid_q, ir_valid_d;
  logic [15:0]           fetch_count_q, fetch_count_d;

  logic accept_s;
  logic slot_free_s;
  logic fetch_s;

  // A word leaves the IR when decode takes it; a new fetch may then refill the slot in the same cycle.
  assign accept_s    = ir_valid_q & instr_ready;
  assign slot_free_s = ~ir_valid_q | accept_s;
  assign fetch_s     = run & slot_free_s & ~redirect;

  // Next-state selection: a redirect beats a fetch, and a fetch beats a plain drain.
  always_comb begin
    pc_d          = pc_q;
    ir_d          = ir_q;
    ir_pc_d       = ir_pc_q;
    ir_valid_d    = ir_valid_q;
    fetch_count_d = fetch_count_q;

    if (redirect) begin
      // The IR contents are left in place; only the valid flag drops, which discards the word.
      pc_d       = redirect_addr;
      ir_valid_d = 1'b0;
    end else if (fetch_s) begin
      ir_d       = pm_data;
      ir_pc_d    = pc_q;
      ir_valid_d = 1'b1;
      pc_d       = pc_q + PC_ONE;
    end else if (accept_s) begin
      ir_valid_d = 1'b0;
    end else begin
      ir_valid_d = ir_valid_q;
    end

    // Decode has consumed the word even when a redirect flushes it in the same cycle, so the word still counts.
    if (accept_s && (fetch_count_q != CNT_MAX)) begin
      fetch_count_d = fetch_count_q + 16'd1;
    end else begin
      fetch_count_d = fetch_count_q;
    end
  end

  // State registers. The reset is synchronous, and it discards any redirect pending on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= PC_ZERO;
      ir_q          <= NOP;
      ir_pc_q       <= PC_ZERO;
      ir_valid_q    <= 1'b0;
      fetch_count_q <= 16'd0;
    end else begin
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      ir_pc_q       <= ir_pc_d;
      ir_valid_q    <= ir_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Force address 0 onto program memory while reset is held, even before the first reset edge.
  assign pm_addr     = rst_n ? pc_q : PC_ZERO;
  assign instr       = ir_q;
  assign instr_pc    = ir_pc_q;
  assign instr_valid = ir_valid_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch.
// Scoreboard: the PCs expected to be accepted are queued as stimulus is planned.
// A negedge monitor pops the queue on each accept and compares PC and data.
// Directed checks sample at 1 time unit after the rising edge.
module tb_instruction_fetch;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          run;
  logic [AW-1:0] pm_addr;
  logic [15:0]   pm_data;
  logic [15:0]   instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic          redirect;
  logic [AW-1:0] redirect_addr;
  logic [15:0]   fetch_count;

  logic [15:0] pm [64];

  typedef struct {
    logic [AW-1:0] pc;
    logic [15:0]   data;
  } sb_item_t;

  sb_item_t sb_q[$];

  int tests_run    = 0;
  int tests_failed = 0;

  assign pm_data = pm[pm_addr];

  instruction_fetch #(.ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .run           (run),
    .pm_addr       (pm_addr),
    .pm_data       (pm_data),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .fetch_count   (fetch_count)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int pc);
    sb_item_t it;
    it.pc   = AW'(pc);
    it.data = pm[pc];
    sb_q.push_back(it);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pop the scoreboard on every word decode accepts at the coming edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected_accept", 32'(sb_q.size()), 32'd1);
      end else begin
        sb_item_t it;
        it = sb_q.pop_front();
        check_eq("sb_pc", 32'(instr_pc), 32'(it.pc));
        check_eq("sb_data", 32'(instr), 32'(it.data));
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) pm[i] = 16'hC000 | 16'(i * 3);
    pm[0] = 16'hA203;
    pm[1] = 16'hA305;

    rst_n = 1'b0; run = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_addr = '0;
    #1;
    check_eq("pm_addr_in_reset", 32'(pm_addr), 32'd0);
    tick(); tick();
    check_eq("rst_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_instr", 32'(instr), 32'hFFFF);
    check_eq("rst_instr_pc", 32'(instr_pc), 32'd0);
    check_eq("rst_count", 32'(fetch_count), 32'd0);

    // First fetches and back-to-back throughput.
    rst_n = 1'b1; run = 1'b1; instr_ready = 1'b1;
    push_exp(0); push_exp(1); push_exp(2);
    tick(); // e1
    check_eq("e1_instr", 32'(instr), 32'hA203);
    check_eq("e1_pc", 32'(instr_pc), 32'd0);
    check_eq("e1_valid", 32'(instr_valid), 32'd1);
    tick(); // e2
    check_eq("e2_instr", 32'(instr), 32'hA305);
    check_eq("e2_pc", 32'(instr_pc), 32'd1);
    check_eq("e2_count", 32'(fetch_count), 32'd1);
    tick(); // e3: PM[2] loaded
    check_eq("e3_count", 32'(fetch_count), 32'd2);

    // Stall for 3 cycles holding PM[2].
    instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("stall_instr", 32'(instr), 32'(pm[2]));
      check_eq("stall_pc", 32'(instr_pc), 32'd2);
      check_eq("stall_pm_addr", 32'(pm_addr), 32'd3);
      check_eq("stall_valid", 32'(instr_valid), 32'd1);
    end
    instr_ready = 1'b1;
    tick(); // e7
    check_eq("release_instr", 32'(instr), 32'(pm[3]));
    check_eq("release_pc", 32'(instr_pc), 32'd3);
    check_eq("release_count", 32'(fetch_count), 32'd3);

    // Redirect to 38 while stalled; the word at 3 is dropped.
    instr_ready = 1'b0; redirect = 1'b1; redirect_addr = 6'd38;
    tick(); // e8
    check_eq("rd38_valid", 32'(instr_valid), 32'd0);
    redirect = 1'b0;
    tick(); // e9
    check_eq("at38_pc", 32'(instr_pc), 32'd38);
    check_eq("at38_valid", 32'(instr_valid), 32'd1);

    // Redirect to 30 with the word at 38 held valid.
    redirect = 1'b1; redirect_addr = 6'd30;
    tick(); // e10
    check_eq("rd30_valid", 32'(instr_valid), 32'd0);
    check_eq("rd30_pm_addr", 32'(pm_addr), 32'd30);
    check_eq("rd30_count", 32'(fetch_count), 32'd3);
    redirect = 1'b0; instr_ready = 1'b1;
    push_exp(30);
    tick(); // e11
    check_eq("at30_pc", 32'(instr_pc), 32'd30);
    check_eq("at30_instr", 32'(instr), 32'(pm[30]));

    // Redirect and accept in the same cycle.
    redirect = 1'b1; redirect_addr = 6'd50;
    tick(); // e12
    check_eq("rdacc_count", 32'(fetch_count), 32'd4);
    check_eq("rdacc_valid", 32'(instr_valid), 32'd0);
    check_eq("rdacc_pm_addr", 32'(pm_addr), 32'd50);
    redirect = 1'b0;
    push_exp(50); push_exp(51);
    tick(); // e13
    check_eq("rdacc_next_pc", 32'(instr_pc), 32'd50);
    tick(); // e14
    check_eq("e14_count", 32'(fetch_count), 32'd5);

    // Wrap through 63 with NOP words.
    pm[63] = 16'hFFFF; pm[0] = 16'hFFFF; pm[1] = 16'hFFFF; pm[2] = 16'hFFFF;
    redirect = 1'b1; redirect_addr = 6'd63;
    tick(); // e15
    check_eq("wrap_rd_count", 32'(fetch_count), 32'd6);
    redirect = 1'b0;
    for (int p = 0; p < 7; p++) push_exp((63 + p) % 64);
    for (int p = 0; p < 3; p++) begin
      tick(); // e16..e18
      check_eq("wrap_pc", 32'(instr_pc), 32'((63 + p) % 64));
      check_eq("wrap_instr", 32'(instr), 32'hFFFF);
      check_eq("wrap_valid", 32'(instr_valid), 32'd1);
    end
    tick(); tick(); tick(); tick(); // e19..e22
    check_eq("pm5_pc", 32'(instr_pc), 32'd5);
    check_eq("e22_count", 32'(fetch_count), 32'd12);

    // run=0 with PM[5] held.
    run = 1'b0; instr_ready = 1'b0;
    tick(); // e23
    check_eq("run0_hold_valid", 32'(instr_valid), 32'd1);
    check_eq("run0_hold_pc", 32'(instr_pc), 32'd5);
    check_eq("run0_pm_addr", 32'(pm_addr), 32'd6);
    instr_ready = 1'b1;
    tick(); // e24
    check_eq("run0_drain_valid", 32'(instr_valid), 32'd0);
    check_eq("run0_drain_count", 32'(fetch_count), 32'd13);
    tick(); // e25
    check_eq("run0_idle_valid", 32'(instr_valid), 32'd0);
    check_eq("run0_idle_pm_addr", 32'(pm_addr), 32'd6);
    run = 1'b1;
    tick(); // e26
    check_eq("rerun_pc", 32'(instr_pc), 32'd6);
    check_eq("rerun_instr", 32'(instr), 32'(pm[6]));

    // Reset mid-stream with a pending redirect, which must be discarded.
    instr_ready = 1'b0; rst_n = 1'b0; redirect = 1'b1; redirect_addr = 6'd20;
    tick(); // e27
    check_eq("mrst_pm_addr", 32'(pm_addr), 32'd0);
    check_eq("mrst_valid", 32'(instr_valid), 32'd0);
    check_eq("mrst_count", 32'(fetch_count), 32'd0);
    check_eq("mrst_instr", 32'(instr), 32'hFFFF);
    rst_n = 1'b1; redirect = 1'b0;
    tick(); // e28
    check_eq("post_rst_pc", 32'(instr_pc), 32'd0);
    check_eq("post_rst_pm_addr", 32'(pm_addr), 32'd1);
    run = 1'b0;
    tick();

    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
